// File: rtl/std_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package std_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/std_div_pipe.sv
// Multi-cycle restoring divider: one shift-subtract step per clock, WIDTH steps
// per operation, optional two's-complement sign handling around the iteration.
module std_div_pipe
  import std_div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("std_div_pipe: WIDTH must be at least 2");
  end

  div_state_e       state_r, state_next;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, div_r, left_r;
  logic             neg_q_r, neg_r_r, div_zero_r;

  logic [WIDTH-1:0] left_mag, right_mag;
  logic             neg_q_in, neg_r_in;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step, q_fin, r_fin;

  if (SIGNED != 0) begin : g_sign_in
    assign left_mag  = left[WIDTH-1]  ? (~left)  + WIDTH'(1) : left;
    assign right_mag = right[WIDTH-1] ? (~right) + WIDTH'(1) : right;
    assign neg_q_in  = left[WIDTH-1] ^ right[WIDTH-1];
    assign neg_r_in  = left[WIDTH-1];
  end else begin : g_unsigned_in
    assign left_mag  = left;
    assign right_mag = right;
    assign neg_q_in  = 1'b0;
    assign neg_r_in  = 1'b0;
  end

  // Remainder stays below the divisor, so the low WIDTH bits of the
  // difference are exact even though the trial value is WIDTH+1 bits wide.
  assign trial    = {rem_r, quo_r[WIDTH-1]};
  assign fits     = (trial >= {1'b0, div_r});
  assign rem_step = trial[WIDTH-1:0] - (fits ? div_r : {WIDTH{1'b0}});
  assign quo_step = {quo_r[WIDTH-2:0], fits};

  if (SIGNED != 0) begin : g_sign_out
    assign q_fin = neg_q_r ? (~quo_step) + WIDTH'(1) : quo_step;
    assign r_fin = neg_r_r ? (~rem_step) + WIDTH'(1) : rem_step;
  end else begin : g_unsigned_out
    assign q_fin = quo_step;
    assign r_fin = rem_step;
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (go) state_next = RUN;
        else    state_next = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_next = DONE;
        else               state_next = RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      rem_r         <= {WIDTH{1'b0}};
      quo_r         <= {WIDTH{1'b0}};
      div_r         <= {WIDTH{1'b0}};
      left_r        <= {WIDTH{1'b0}};
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      div_zero_r    <= 1'b0;
      out_quotient  <= {WIDTH{1'b0}};
      out_remainder <= {WIDTH{1'b0}};
      done          <= 1'b0;
    end else begin
      state_r <= state_next;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go) begin
            cnt_r      <= {CW{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= left_mag;
            div_r      <= right_mag;
            left_r     <= left;
            neg_q_r    <= neg_q_in;
            neg_r_r    <= neg_r_in;
            div_zero_r <= (right == {WIDTH{1'b0}});
          end
        end
        RUN: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // Divide-by-zero results are fixed regardless of operand signs.
            out_quotient  <= div_zero_r ? {WIDTH{1'b1}} : q_fin;
            out_remainder <= div_zero_r ? left_r : r_fin;
            done          <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_div_pipe.sv
// Scoreboard bench for std_div_pipe at WIDTH=8, one unsigned and one signed instance.
module tb_std_div_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go0 = 1'b0, go1 = 1'b0;
  logic [7:0] left0 = 8'd0, right0 = 8'd0, left1 = 8'd0, right1 = 8'd0;
  logic [7:0] quo0, rem0, quo1, rem1;
  logic       done0, done1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    int         cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  std_div_pipe #(.WIDTH(8), .SIGNED(0)) u_div_u (
    .clk(clk), .reset(reset), .go(go0), .left(left0), .right(right0),
    .out_quotient(quo0), .out_remainder(rem0), .done(done0)
  );

  std_div_pipe #(.WIDTH(8), .SIGNED(1)) u_div_s (
    .clk(clk), .reset(reset), .go(go1), .left(left1), .right(right1),
    .out_quotient(quo1), .out_remainder(rem1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int         sa, sb, qi, ri;
    logic [7:0] qb, rb;
    if (b == 8'd0) return {8'hFF, a};
    if (!sgn) begin
      qb = a / b;
      rb = a % b;
      return {qb, rb};
    end
    sa = $signed(a);
    sb = $signed(b);
    if (sa == -128 && sb == -1) return {8'h80, 8'h00};
    qi = sa / sb;
    ri = sa % sb;
    qb = qi[7:0];
    rb = ri[7:0];
    return {qb, rb};
  endfunction

  // Compare each done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (sb0.size() == 0) chk("u_spurious_done", {31'd0, done0}, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("u_quotient", {24'd0, quo0}, {24'd0, e.q});
        chk("u_remainder", {24'd0, rem0}, {24'd0, e.r});
        chk("u_latency", cyc, e.cyc);
      end
    end
    if (done1) begin
      if (sb1.size() == 0) chk("s_spurious_done", {31'd0, done1}, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("s_quotient", {24'd0, quo1}, {24'd0, e.q});
        chk("s_remainder", {24'd0, rem1}, {24'd0, e.r});
        chk("s_latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge of an IDLE cycle: present operands and queue the result.
  task automatic start(input bit sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] m;
    exp_t e;
    m = model(sel, a, b);
    e.q = m[15:8];
    e.r = m[7:0];
    e.cyc = cyc + 9;
    if (sel) begin
      go1 = 1'b1; left1 = a; right1 = b; sb1.push_back(e);
    end else begin
      go0 = 1'b1; left0 = a; right0 = b; sb0.push_back(e);
    end
  endtask

  task automatic drain(input bit sel);
    for (int i = 0; i < 40 && ((sel ? sb1.size() : sb0.size()) != 0); i++) @(negedge clk);
    if (sel) begin
      if (sb1.size() != 0) begin chk("s_drain_timeout", sb1.size(), 32'd0); sb1.delete(); end
    end else begin
      if (sb0.size() != 0) begin chk("u_drain_timeout", sb0.size(), 32'd0); sb0.delete(); end
    end
  endtask

  task automatic single_op(input bit sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start(sel, a, b);
    @(negedge clk);
    go0 = 1'b0;
    go1 = 1'b0;
    left0 = 8'hA5; right0 = 8'h5A; left1 = 8'hA5; right1 = 8'h5A;
    drain(sel);
  endtask

  logic [7:0] ua [0:7] = '{8'd100, 8'd37, 8'd255, 8'd0, 8'd255, 8'd200, 8'd1, 8'd128};
  logic [7:0] ub [0:7] = '{8'd7,   8'd0,  8'd1,   8'd5, 8'd255, 8'd13,  8'd2, 8'd3};
  logic [7:0] sa_t [0:8] = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'h05, 8'hFB, 8'h7F, 8'hF0, 8'h00};
  logic [7:0] sb_t [0:8] = '{8'h02, 8'hFE, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h80, 8'hFB, 8'hFD};
  logic [7:0] ca [0:3] = '{8'd200, 8'd17, 8'd99, 8'd250};
  logic [7:0] cb [0:3] = '{8'd9,   8'd4,  8'd0, 8'd16};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_u_quotient", {24'd0, quo0}, 32'd0);
    chk("reset_u_remainder", {24'd0, rem0}, 32'd0);
    chk("reset_u_done", {31'd0, done0}, 32'd0);
    chk("reset_s_quotient", {24'd0, quo1}, 32'd0);
    chk("reset_s_remainder", {24'd0, rem1}, 32'd0);
    chk("reset_s_done", {31'd0, done1}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) single_op(1'b0, ua[i], ub[i]);
    for (int i = 0; i < 9; i++) single_op(1'b1, sa_t[i], sb_t[i]);
    for (int i = 0; i < 6; i++) single_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    for (int i = 0; i < 6; i++) single_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));

    // Reset four cycles into an operation: no result, cleared outputs.
    @(negedge clk);
    go0 = 1'b1; left0 = 8'd100; right0 = 8'd7;
    @(negedge clk);
    go0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_quotient", {24'd0, quo0}, 32'd0);
    chk("abort_remainder", {24'd0, rem0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    repeat (12) @(negedge clk);
    single_op(1'b0, 8'd9, 8'd3);

    // go held high; operands disturbed while busy.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      start(1'b0, ca[k], cb[k]);
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (k == 3 && j == 1) go0 = 1'b0;
        if (j <= 6) begin
          left0 = 8'($urandom_range(0, 255));
          right0 = 8'($urandom_range(0, 255));
        end
      end
    end
    drain(1'b0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/std_div_pipe.md
STD_DIV_PIPE -- requirements
Module: std_div_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 2..64).
REQ-002 The module SHALL have parameter SIGNED, default 0: 0 = unsigned division, 1 = two's-complement signed division.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port go  input  1  is the start request, sampled only in IDLE.
REQ-006 Port left  input  WIDTH  is the dividend, latched on acceptance.
REQ-007 Port right  input  WIDTH  is the divisor, latched on acceptance.
REQ-008 Port out_quotient  output  WIDTH  is the registered quotient of the last completed operation.
REQ-009 Port out_remainder  output  WIDTH  is the registered remainder of the last completed operation.
REQ-010 Port done  output  1  is a one-cycle pulse marking result validity.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE with go=1 at an edge SHALL latch left/right and enter RUN; go=0 SHALL stay IDLE.
REQ-013 RUN SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH steps, counted by a clog2(WIDTH+1)-bit counter, then enter DONE.
REQ-014 On the RUN->DONE edge, out_quotient/out_remainder SHALL update; done SHALL be 1 for exactly the single DONE cycle; DONE->IDLE unconditionally.
REQ-015 Latency: go accepted at the edge ending cycle c -> done high in cycle c+WIDTH+1, for every operand value including the special cases.
REQ-016 go and operand changes while in RUN or DONE SHALL be ignored; go still high in the IDLE cycle after DONE SHALL start a new operation with freshly sampled operands.
REQ-017 Outputs SHALL hold their last values between operations and change only on a RUN->DONE edge or reset.
REQ-018 Unsigned: quotient = floor(left/right), remainder = left - quotient*right.
REQ-019 Signed: the iteration SHALL operate on WIDTH-bit unsigned magnitudes; quotient truncates toward zero and is negated iff the operand signs differ; the remainder takes the dividend's sign.
REQ-020 Divide by zero: quotient = all ones and remainder = left, in both modes, with the normal latency.
REQ-021 Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, with no error flag.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, out_quotient=0, out_remainder=0, done=0 and the counter to 0, overriding go.
REQ-023 reset during RUN or DONE SHALL abandon the operation with no done pulse; the first go after reset deasserts SHALL be accepted normally.

Structure
REQ-024 A shared package std_div_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the iteration-counter width function.
REQ-025 The iteration SHALL be inline; no sub-module is required. Sign pre- and post-conditioning SHALL be generated only when SIGNED=1.
REQ-026 A simulation-only check SHALL issue $error if WIDTH < 2.

Verification (WIDTH=8)
REQ-027 SIGNED=0, go with 100/7 -> done high exactly 9 cycles after acceptance; quotient 14, remainder 2.
REQ-028 SIGNED=0, 37/0 -> quotient 0xFF, remainder 37, same latency.
REQ-029 SIGNED=1, -7/2 -> quotient 0xFD (-3), remainder 0xFF (-1); 7/-2 -> quotient 0xFD, remainder 0x01.
REQ-030 SIGNED=1, -128/-1 -> quotient 0x80, remainder 0x00.
REQ-031 Accept 100/7, then assert reset for one cycle 4 cycles later -> no done pulse, outputs 0; a new 9/3 afterwards -> quotient 3, remainder 0.
REQ-032 go held high continuously, with operands changed mid-RUN -> the first result uses the originally latched operands; done pulses every 10 cycles, each result matching the operands sampled in the preceding IDLE cycle.
